// File: rtl/led_sequencer.sv
// Palette-driven LED colour sequencer: steps or fades through a writable palette,
// posts each new colour word to the LED register and drives active-high PWM outputs.
module led_sequencer #(
    parameter int          NUM_ENTRIES = 8,
    parameter int          IDX_W       = 3,
    parameter int          CNT_W       = 22,
    parameter int          PWM_W       = 8,
    parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [CNT_W-1:0] dwell,
    input  logic [IDX_W:0]   num_steps,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_idx,
    input  logic [31:0]      pal_data,
    output logic [31:0]      color,
    output logic [IDX_W-1:0] step_idx,
    output logic             wrap,
    output logic             dmem_wren,
    output logic [31:0]      dmem_address,
    output logic [31:0]      dmem_data_in,
    output logic             pwm_led,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b
);

    // state | meaning
    // IDLE  | stopped; colour and index held, no writes
    // LOAD  | latch pal[step_idx] into colour and post it to the LED register
    // DWELL | count the dwell down, then advance the index
    // FADE  | move each byte one step per PWM period toward pal[step_idx]
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;
    localparam logic [1:0] ST_FADE  = 2'd3;

    localparam logic [IDX_W:0] ENTRIES_LIM = (IDX_W + 1)'(NUM_ENTRIES);
    localparam logic [IDX_W:0] ONE_STEP    = (IDX_W + 1)'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [PWM_W-1:0] pc;
    logic [31:0]      pal [NUM_ENTRIES];

    logic [31:0]      cur_entry;
    logic [31:0]      fade_word;
    logic [IDX_W:0]   n_eff;
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] next_idx;
    logic             fade_tick;

    function automatic logic [31:0] default_entry(input int i);
        case (i)
            0:       return 32'hFFFF_0000;
            1:       return 32'hFFFF_FF00;
            2:       return 32'hFF00_FF00;
            3:       return 32'h0000_FFFF;
            4:       return 32'h0000_00FF;
            5:       return 32'h00FF_00FF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

    always_comb begin
        if (num_steps == '0) begin
            n_eff = ONE_STEP;
        end else if (num_steps > ENTRIES_LIM) begin
            n_eff = ENTRIES_LIM;
        end else begin
            n_eff = num_steps;
        end
    end

    // Compare against n_eff rather than testing equality so a shrunk num_steps
    // with the index already beyond it still returns to entry 0.
    assign idx_inc  = {1'b0, step_idx} + ONE_STEP;
    assign next_idx = (idx_inc >= n_eff) ? '0 : idx_inc[IDX_W-1:0];

    // Explicit decode keeps non-power-of-two depths free of out-of-range reads.
    always_comb begin
        cur_entry = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (step_idx == IDX_W'(i)) begin
                cur_entry = pal[i];
            end
        end
    end

    assign fade_word = {toward(color[31:24], cur_entry[31:24]),
                        toward(color[23:16], cur_entry[23:16]),
                        toward(color[15:8],  cur_entry[15:8]),
                        toward(color[7:0],   cur_entry[7:0])};

    assign fade_tick = (pc == '1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pal[i] <= default_entry(i);
            end
        end else if (pal_we) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (pal_idx == IDX_W'(i)) begin
                    pal[i] <= pal_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else begin
            pc <= pc + PWM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            step_idx     <= '0;
            color        <= '0;
            dmem_data_in <= '0;
            count        <= '0;
            dmem_wren    <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            dmem_wren <= 1'b0;
            wrap      <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        color        <= cur_entry;
                        dmem_data_in <= cur_entry;
                        dmem_wren    <= 1'b1;
                        count        <= dwell;
                        state        <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        if (count != '0) begin
                            count <= count - CNT_W'(1);
                        end else begin
                            step_idx <= next_idx;
                            wrap     <= (next_idx == '0) &&
                                        ((step_idx != '0) || (n_eff == ONE_STEP));
                            state    <= mode ? ST_FADE : ST_LOAD;
                        end
                    end
                    ST_FADE: begin
                        if (color == cur_entry) begin
                            count <= dwell;
                            state <= ST_DWELL;
                        end else if (fade_tick) begin
                            color        <= fade_word;
                            dmem_data_in <= fade_word;
                            dmem_wren    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dmem_address = LED_ADDR;

    assign pwm_led = pc < color[31 -: PWM_W];
    assign pwm_r   = pc < color[23 -: PWM_W];
    assign pwm_g   = pc < color[15 -: PWM_W];
    assign pwm_b   = pc < color[7  -: PWM_W];

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised RGB/status LED colour sequencer. It replaces the hard-coded six-colour dwell loop in the top level.
- Holds a writable colour palette and steps through a runtime-selected number of entries, with a runtime dwell time. Two modes: hard step, or linear fade between entries.
- Emits a one-cycle memory-mapped write of each new colour word to the LED register.
- Drives active-high PWM outputs for LED/R/G/B directly. The top level inverts them for the board pins.

Parameters:
- NUM_ENTRIES, 8, palette depth (must be ≥1; power of two not required).
- IDX_W, 3, palette index width (≥ clog2(NUM_ENTRIES)).
- CNT_W, 22, dwell counter width.
- PWM_W, 8, PWM counter width. Each colour byte is compared against the top PWM_W bits; PWM_W=8 means a direct byte compare.
- LED_ADDR, 32'hFFFFFFFC, address driven on dmem_address.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run sequencer when 1.
- mode  in  1  0 = STEP, 1 = FADE; sampled when leaving DWELL.
- dwell  in  CNT_W  dwell cycles per entry.
- num_steps  in  IDX_W+1  active palette entries.
- pal_we  in  1  palette write strobe.
- pal_idx  in  IDX_W  palette write index.
- pal_data  in  32  palette word {led,r,g,b} bytes [31:24],[23:16],[15:8],[7:0].
- color  out  32  currently displayed colour word.
- step_idx  out  IDX_W  current palette index.
- wrap  out  1  one-cycle pulse when the index wraps to 0.
- dmem_wren  out  1  one-cycle write strobe.
- dmem_address  out  32  constant LED_ADDR.
- dmem_data_in  out  32  colour word written; equals color whenever dmem_wren=1.
- pwm_led, pwm_r, pwm_g, pwm_b  out  1 each  active-high PWM.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - State goes to IDLE; step_idx=0, color=0, dmem_data_in=0, count=0, PWM counter=0.
  - dmem_wren, wrap and all PWM outputs go to 0.
  - Palette reloads defaults: entry0..5 = FFFF0000, FFFFFF00, FF00FF00, 0000FFFF, 000000FF, 00FF00FF. Entries ≥6 = 0. If NUM_ENTRIES<6, the list is truncated.
- Derived values:
  - n_eff = 1 if num_steps==0; NUM_ENTRIES if num_steps>NUM_ENTRIES; else num_steps.
  - next = 0 if step_idx+1 ≥ n_eff, else step_idx+1. This also covers num_steps being reduced below the current index.
- Palette writes:
  - pal_we=1 with pal_idx<NUM_ENTRIES writes at the clock edge, in any state. Out-of-range pal_idx is ignored.
  - A new entry takes effect at the next LOAD or fade tick, never retroactively.
- FSM states: IDLE, LOAD, DWELL, FADE. enable=0 in any state forces IDLE at the next edge; color and step_idx hold, no dmem_wren.
  - IDLE: when enable=1, go to LOAD.
  - LOAD: color<=pal[step_idx]; dmem_data_in<=pal[step_idx]; dmem_wren<=1; count<=dwell; go to DWELL.
  - DWELL:
    - If count>0, count decrements.
    - Otherwise step_idx<=next, and wrap<=1 if next==0 (only when step_idx≠0 or n_eff==1).
    - Then go to LOAD if mode==0, or FADE if mode==1.
  - FADE:
    - On each fade tick (the cycle where the PWM counter equals all-ones), each of the 4 colour bytes moves 1 toward pal[step_idx] (increment if below, decrement if above). dmem_wren<=1 with the new word.
    - When color==pal[step_idx] at a clock edge: count<=dwell, go to DWELL, no write.
- Registered outputs and timing:
  - dmem_wren and wrap are registered and high for exactly one cycle per event.
  - In STEP mode, writes occur every dwell+2 cycles.
  - First write appears 2 edges after enable rises from IDLE.
- PWM:
  - Free-running PWM_W-bit counter pc, runs regardless of enable.
  - A channel is high when pc < its byte (top PWM_W bits). Byte 00 gives always low; FF gives 255/256 duty at PWM_W=8.
- Arithmetic: the dwell counter never underflows (a zero dwell goes straight to the next transition). Byte fades saturate at the target and never wrap.
- Reset mid-operation (mid-dwell or mid-fade) aborts immediately to the reset values above.

Test Plan:
1. Reset, then enable=1, mode=0, dwell=3, num_steps=6:
   - dmem_wren pulses every 5 cycles with FFFF0000, FFFFFF00, FF00FF00, 0000FFFF, 000000FF, 00FF00FF, then FFFF0000.
   - wrap pulses once per cycle of six.
   - dmem_address stays FFFFFFFC.
2. Write pal[0]=00804001, num_steps=1, dwell=0:
   - Over 256 cycles pwm_r high 128, pwm_g high 64, pwm_b high 1, pwm_led high 0.
   - wrap pulses on every repeat of entry 0.
3. mode=1, num_steps=2, pal[0]=00000010, pal[1]=00000000, dwell=0:
   - After entry 0 loads, color byte0 decrements 10→00 at one step per 256 cycles (16 writes, each a new word).
   - Then DWELL, then fade back up to 10.
4. enable dropped mid-DWELL at step_idx=2:
   - IDLE next cycle; color stays FF00FF00; no writes.
   - enable=1 again: LOAD rewrites FF00FF00 as entry 2.
5. reset driven low mid-FADE between edges:
   - color, dmem_wren and PWM outputs go to 0 before the next clk edge.
   - After release, the palette holds defaults.
6. Out-of-range index handling:
   - num_steps=0 behaves as 1.
   - num_steps=9 clamps to 8.
   - pal_we with pal_idx=7 when NUM_ENTRIES=6 leaves the palette unchanged.
   - Reducing num_steps from 6 to 2 while step_idx=4 makes next=0.
